alu_accum_pipe: RTL and testbench
=================================

Name: alu_accum_pipe

Overview:
- Parametrised two-stage operand/ALU/accumulator datapath, generalising the team's fixed 4-bit operand-register + ALU + result-register block.
- Each operand is either an external value or the running accumulator (last ALU result).
- Adds valid/ready handshakes on input and output, back-pressure stalls, and correct accumulator chaining for back-to-back operations.
- Carry/borrow is kept in the result MSB; zero flag provided.

Parameters:
- WIDTH, 4, operand/accumulator width in bits; result is WIDTH+1.
- OPW, 3, width of ALU op select (fixed encoding below; must be 3).

Ports:
- CLK  input  1  clock, rising-edge
- Reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request carries a valid operation
- in_ready  output  1  block can accept a request this cycle
- Operand_A  input  WIDTH  external A operand
- Operand_B  input  WIDTH  external B operand
- Sel_A  input  1  1: A = Operand_A; 0: A = accumulator
- Sel_B  input  1  1: B = Operand_B; 0: B = accumulator
- ALU_SEL  input  OPW  operation code
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  Result holds an unconsumed result
- out_ready  input  1  consumer accepts Result this cycle
- Result  output  WIDTH+1  {carry/borrow, value}
- zero  output  1  Result[WIDTH-1:0] == 0, registered with Result

Behaviour:
- Reset asserted: stage-1 valid=0, operand regs=0, acc=0, Result=0, out_valid=0, zero=0; in_ready is 1 once released. Reset mid-operation discards all in-flight ops.
- Stage 1 (OP): on a handshake (in_valid && in_ready at the rising edge), capture Operand_A, Operand_B, Sel_A, Sel_B and ALU_SEL; s1_valid=1.
- Operand select is resolved in stage 2 (EX), not stage 1. A selects acc when the captured Sel_A=0; B likewise. acc always equals the low WIDTH bits of the most recently executed op, so back-to-back chained ops need no bubble.
- Stage 2 (EX): when s1_valid && !stall, compute and register Result, set out_valid=1, and update acc = Result[WIDTH-1:0].
- stall = out_valid && !out_ready.
- Result register update: loads when not stalled; otherwise holds. out_valid clears when the result is consumed and no new op executes.
- in_ready = !(s1_valid && stall). It is combinational, with no dependency on in_valid.
- Latency: handshake at edge N gives Result/out_valid after edge N+1. Throughput is 1 op/cycle with out_ready=1.
- Ops (A, B are WIDTH bits; result is WIDTH+1):
  - 000 ADD: A+B, carry in MSB
  - 001 SUB: A-B, MSB=1 on borrow (A<B), low bits mod 2^WIDTH
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A by 1, MSB = A[WIDTH-1]
  - 111 PASS B
  - Logic ops set MSB=0.
- acc_clr: acc=0 at the next edge and wins over a simultaneous EX write. The EX op in that same cycle still uses the pre-clear acc, and its Result is still produced. Pipeline valid bits are unaffected.
- Stall: s1 contents and Result hold. acc is not modified by held ops.
- Wrap-around: all arithmetic is mod 2^WIDTH in the low bits. The carry bit never feeds back into acc.

Test Plan:
- Reset then idle (WIDTH=4): out_valid=0, Result=5'b00000, in_ready=1. Deassert Reset mid-clock and check there are no spurious out_valid pulses.
- Single ADD: A=4'hA, B=4'h7, Sel_A=Sel_B=1, op=000, handshake at edge N -> Result=5'h11, zero=0, out_valid high after N+1.
- Back-to-back chaining with out_ready=1:
  - op1 ADD 3+4 -> 5'h07
  - op2 ADD acc+1 (Sel_A=0) on the next cycle -> 5'h08
  - op3 SUB acc-9 (Sel_A=0) -> 5'h1F (borrow=1, value 4'hF)
  - All with no bubbles.
- Back-pressure:
  - Issue ADD 1+1, then PASS B=5, then XOR 4'hF^4'hF, while out_ready=0.
  - Expect: in_ready drops after the 2nd handshake; Result holds 5'h02.
  - Raise out_ready: results 5'h02, 5'h05, 5'h00 (zero=1) in order, each exactly once.
- acc_clr collision: acc=4'h6; acc_clr asserted in the same cycle an op ADD acc+2 executes -> Result=5'h08, next acc=0. The following ADD acc+2 -> 5'h02.
- WIDTH=8 regression: ADD 8'hFF+8'h01 -> Result=9'h100, zero=1. Then SHL acc (Sel_A=0) -> 9'h000. Then asynchronous reset mid-stall clears out_valid immediately.

Source files
------------

// File: rtl/alu_accum_pipe.sv
// Two-stage operand/ALU/accumulator datapath with valid/ready handshakes.
// Each operand is an external value or the running accumulator, resolved in EX.
module alu_accum_pipe #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Sel_A,
  input  logic             Sel_B,
  input  logic [OPW-1:0]   ALU_SEL,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Result,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_PSB = 3'b111;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_sel_a;
  logic             s1_sel_b;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] acc;

  logic             stall;
  logic             in_fire;
  logic             ex_go;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   alu_y;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !(s1_valid && stall);
  assign in_fire  = in_valid && in_ready;
  assign ex_go    = s1_valid && !stall;

  // Late operand select lets a chained op see the result of the op just ahead.
  assign op_a = s1_sel_a ? s1_a : acc;
  assign op_b = s1_sel_b ? s1_b : acc;

  always_comb begin
    alu_y = '0;
    unique case (s1_op)
      OP_ADD: alu_y = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: alu_y = {1'b0, op_a} - {1'b0, op_b};
      OP_AND: alu_y = {1'b0, op_a & op_b};
      OP_OR:  alu_y = {1'b0, op_a | op_b};
      OP_XOR: alu_y = {1'b0, op_a ^ op_b};
      OP_NOT: alu_y = {1'b0, ~op_a};
      OP_SHL: alu_y = {op_a, 1'b0};
      OP_PSB: alu_y = {1'b0, op_b};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel_a <= 1'b0;
      s1_sel_b <= 1'b0;
      s1_op    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= Operand_A;
      s1_b     <= Operand_B;
      s1_sel_a <= Sel_A;
      s1_sel_b <= Sel_B;
      s1_op    <= ALU_SEL;
    end else if (ex_go) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      Result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (ex_go) begin
      Result    <= alu_y;
      zero      <= (alu_y[WIDTH-1:0] == '0);
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear beats a same-cycle EX write; the carry never reaches acc.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (ex_go)
      acc <= alu_y[WIDTH-1:0];
  end

endmodule

// File: tb/tb_alu_accum_pipe.sv
// Directed bench for alu_accum_pipe: WIDTH=4 instance plus a WIDTH=8 instance.
// Hand-computed expected values, checked with immediate assertions.
module tb_alu_accum_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  logic       Reset;
  logic       in_valid, in_ready;
  logic [3:0] Operand_A, Operand_B;
  logic       Sel_A, Sel_B;
  logic [2:0] ALU_SEL;
  logic       acc_clr;
  logic       out_valid, out_ready;
  logic [4:0] Result;
  logic       zero;

  logic       rst8;
  logic       iv8, ir8;
  logic [7:0] a8, b8;
  logic       sa8, sb8;
  logic [2:0] op8;
  logic       clr8;
  logic       ov8, or8;
  logic [8:0] res8;
  logic       z8;

  alu_accum_pipe #(.WIDTH(4), .OPW(3)) dut (
    .CLK(CLK), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operand_A(Operand_A), .Operand_B(Operand_B),
    .Sel_A(Sel_A), .Sel_B(Sel_B),
    .ALU_SEL(ALU_SEL), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .zero(zero)
  );

  alu_accum_pipe #(.WIDTH(8), .OPW(3)) dut8 (
    .CLK(CLK), .Reset(rst8),
    .in_valid(iv8), .in_ready(ir8),
    .Operand_A(a8), .Operand_B(b8),
    .Sel_A(sa8), .Sel_B(sb8),
    .ALU_SEL(op8), .acc_clr(clr8),
    .out_valid(ov8), .out_ready(or8),
    .Result(res8), .zero(z8)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b,
                     input logic sa, input logic sb,
                     input logic [2:0] op);
    in_valid  = 1'b1;
    Operand_A = a;
    Operand_B = b;
    Sel_A     = sa;
    Sel_B     = sb;
    ALU_SEL   = op;
  endtask

  initial begin
    Reset = 1'b0; in_valid = 1'b0; Operand_A = '0; Operand_B = '0;
    Sel_A = 1'b1; Sel_B = 1'b1; ALU_SEL = '0; acc_clr = 1'b0;
    out_ready = 1'b1;
    rst8 = 1'b0; iv8 = 1'b0; a8 = '0; b8 = '0; sa8 = 1'b1; sb8 = 1'b1;
    op8 = '0; clr8 = 1'b0; or8 = 1'b1;

    // Reset and idle
    #12;
    chk("rst_ov", 16'(out_valid), 16'h0);
    chk("rst_res", 16'(Result), 16'h00);
    chk("rst_zero", 16'(zero), 16'h0);
    chk("rst_ir", 16'(in_ready), 16'h1);
    #1 Reset = 1'b1; rst8 = 1'b1;
    step();
    chk("idle_ov1", 16'(out_valid), 16'h0);
    step();
    chk("idle_ov2", 16'(out_valid), 16'h0);
    chk("idle_ir", 16'(in_ready), 16'h1);

    // Single ADD A+7 = 0x11
    req(4'hA, 4'h7, 1'b1, 1'b1, 3'b000);
    step();
    chk("add_lat_ov", 16'(out_valid), 16'h0);
    in_valid = 1'b0;
    step();
    chk("add_ov", 16'(out_valid), 16'h1);
    chk("add_res", 16'(Result), 16'h11);
    chk("add_zero", 16'(zero), 16'h0);
    step();
    chk("add_drain", 16'(out_valid), 16'h0);

    // Chaining: 3+4, acc+1, acc-9
    req(4'h3, 4'h4, 1'b1, 1'b1, 3'b000);
    step();
    req(4'h0, 4'h1, 1'b0, 1'b1, 3'b000);
    chk("ch_ir1", 16'(in_ready), 16'h1);
    step();
    chk("ch_r1", 16'(Result), 16'h07);
    chk("ch_ov1", 16'(out_valid), 16'h1);
    req(4'h0, 4'h9, 1'b0, 1'b1, 3'b001);
    step();
    chk("ch_r2", 16'(Result), 16'h08);
    chk("ch_ov2", 16'(out_valid), 16'h1);
    in_valid = 1'b0;
    step();
    chk("ch_r3", 16'(Result), 16'h1F);
    chk("ch_ov3", 16'(out_valid), 16'h1);
    step();
    chk("ch_drain", 16'(out_valid), 16'h0);

    // Back-pressure
    out_ready = 1'b0;
    req(4'h1, 4'h1, 1'b1, 1'b1, 3'b000);
    chk("bp_ir0", 16'(in_ready), 16'h1);
    step();
    req(4'h0, 4'h5, 1'b1, 1'b1, 3'b111);
    chk("bp_ir1", 16'(in_ready), 16'h1);
    step();
    chk("bp_res1", 16'(Result), 16'h02);
    chk("bp_ov1", 16'(out_valid), 16'h1);
    chk("bp_ir2", 16'(in_ready), 16'h0);
    req(4'hF, 4'hF, 1'b1, 1'b1, 3'b100);
    step();
    chk("bp_hold", 16'(Result), 16'h02);
    chk("bp_ir3", 16'(in_ready), 16'h0);
    step();
    chk("bp_hold2", 16'(Result), 16'h02);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_res2", 16'(Result), 16'h05);
    chk("bp_ov2", 16'(out_valid), 16'h1);
    step();
    chk("bp_res3", 16'(Result), 16'h00);
    chk("bp_z3", 16'(zero), 16'h1);
    chk("bp_ov3", 16'(out_valid), 16'h1);
    step();
    chk("bp_drain", 16'(out_valid), 16'h0);

    // acc_clr collision
    req(4'h0, 4'h6, 1'b1, 1'b1, 3'b111);
    step();
    req(4'h0, 4'h2, 1'b0, 1'b1, 3'b000);
    step();
    chk("clr_r6", 16'(Result), 16'h06);
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("clr_r8", 16'(Result), 16'h08);
    req(4'h0, 4'h2, 1'b0, 1'b1, 3'b000);
    step();
    in_valid = 1'b0;
    step();
    chk("clr_r2", 16'(Result), 16'h02);
    chk("clr_z", 16'(zero), 16'h0);

    // WIDTH=8: FF+01, then SHL acc, then reset mid-stall
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sa8 = 1'b1; sb8 = 1'b1;
    op8 = 3'b000;
    step();
    sa8 = 1'b0; op8 = 3'b110;
    step();
    iv8 = 1'b0;
    chk("w8_add", 16'(res8), 16'h100);
    chk("w8_addz", 16'(z8), 16'h1);
    step();
    chk("w8_shl", 16'(res8), 16'h000);
    chk("w8_shlz", 16'(z8), 16'h1);
    chk("w8_ov", 16'(ov8), 16'h1);
    or8 = 1'b0;
    iv8 = 1'b1; sa8 = 1'b1; sb8 = 1'b1; b8 = 8'h55; op8 = 3'b111;
    step();
    iv8 = 1'b0;
    chk("w8_stall_ir", 16'(ir8), 16'h0);
    chk("w8_stall_ov", 16'(ov8), 16'h1);
    #2 rst8 = 1'b0;
    #1;
    chk("w8_rst_ov", 16'(ov8), 16'h0);
    chk("w8_rst_res", 16'(res8), 16'h000);
    chk("w8_rst_ir", 16'(ir8), 16'h1);
    step();
    rst8 = 1'b1;
    or8  = 1'b1;
    step();
    chk("w8_post_ov", 16'(ov8), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
